// File: rtl/neuron_loader.sv
// Byte-stream loader: routes N image bytes, N weight bytes and a 3-byte threshold.
// Optional trailing checksum byte when NEURON_LOADER_CHECKSUM_EN is defined.
module neuron_loader #(
  parameter int unsigned N     = 64,
  parameter int unsigned PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             chip_sel,
  input  logic             wr_en,
  input  logic [7:0]       bus_data,
  output logic             ready,
  output logic             busy,
  output logic             img_wr_en,
  output logic             wgt_wr_en,
  output logic [PTR_W-1:0] wr_data_ptr,
  output logic [7:0]       wr_data,
  output logic [21:0]      threshold,
  output logic             threshold_ready,
  output logic             load_done,
  output logic             load_err
);

  // Counter also indexes the three threshold bytes, so it needs at least 2 bits.
  localparam int unsigned     CNT_W = (PTR_W > 2) ? PTR_W : 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`ifdef NEURON_LOADER_CHECKSUM_EN
  localparam int unsigned SH_W = 22;
`else
  localparam int unsigned SH_W = 16;
`endif

`ifdef NEURON_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_WGT, LOAD_THR, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD_IMG, LOAD_WGT, LOAD_THR, DONE} state_t;
`endif

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SH_W-1:0]   r_shadow, w_shadow_nxt;
  logic [21:0]       w_thr_new;
  logic              w_accept, w_img_we, w_wgt_we, w_commit;

  assign w_accept = chip_sel & wr_en & ready;

`ifdef NEURON_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       w_sum_ok, w_err;

  assign w_sum_ok  = (r_sum == bus_data);
  assign w_thr_new = r_shadow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum    <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= w_err;
      if (w_accept) begin
        case (r_state)
          IDLE:                         r_sum <= bus_data;
          LOAD_IMG, LOAD_WGT, LOAD_THR: r_sum <= r_sum + bus_data;
          default:                      ;
        endcase
      end
    end
  end
`else
  // Top threshold byte arrives on the committing edge, so it is taken straight off the bus.
  assign w_thr_new = {bus_data[5:0], r_shadow[15:0]};
  assign load_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      case (r_state)
        IDLE:     w_next = (N == 1) ? LOAD_WGT : LOAD_IMG;
        LOAD_IMG: if (r_cnt == LAST) w_next = LOAD_WGT;
        LOAD_WGT: if (r_cnt == LAST) w_next = LOAD_THR;
`ifdef NEURON_LOADER_CHECKSUM_EN
        LOAD_THR: if (r_cnt == CNT_W'(2)) w_next = CHECK;
        CHECK:    w_next = w_sum_ok ? DONE : IDLE;
`else
        LOAD_THR: if (r_cnt == CNT_W'(2)) w_next = DONE;
`endif
        default:  ;
      endcase
    end
    if (r_state == DONE) w_next = IDLE;
  end

  always_comb begin
    ready        = (r_state != DONE);
    busy         = (r_state != IDLE);
    w_img_we     = 1'b0;
    w_wgt_we     = 1'b0;
    w_commit     = 1'b0;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
`ifdef NEURON_LOADER_CHECKSUM_EN
    w_err        = 1'b0;
`endif
    if (w_accept) begin
      case (r_state)
        IDLE, LOAD_IMG: begin
          w_img_we  = 1'b1;
          w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
        LOAD_WGT: begin
          w_wgt_we  = 1'b1;
          w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
        end
        LOAD_THR: begin
          if (r_cnt == CNT_W'(0))      w_shadow_nxt[7:0]  = bus_data;
          else if (r_cnt == CNT_W'(1)) w_shadow_nxt[15:8] = bus_data;
`ifdef NEURON_LOADER_CHECKSUM_EN
          else                         w_shadow_nxt[21:16] = bus_data[5:0];
`else
          w_commit = (r_cnt == CNT_W'(2));
`endif
          w_cnt_nxt = (r_cnt == CNT_W'(2)) ? '0 : r_cnt + CNT_W'(1);
        end
`ifdef NEURON_LOADER_CHECKSUM_EN
        CHECK: begin
          w_commit = w_sum_ok;
          w_err    = !w_sum_ok;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_shadow        <= '0;
      img_wr_en       <= 1'b0;
      wgt_wr_en       <= 1'b0;
      wr_data_ptr     <= '0;
      wr_data         <= '0;
      threshold       <= '0;
      threshold_ready <= 1'b0;
      load_done       <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_shadow        <= w_shadow_nxt;
      img_wr_en       <= w_img_we;
      wgt_wr_en       <= w_wgt_we;
      threshold_ready <= w_commit;
      load_done       <= w_commit;
      if (w_img_we || w_wgt_we) begin
        wr_data_ptr <= r_cnt[PTR_W-1:0];
        wr_data     <= bus_data;
      end
      if (w_commit) threshold <= w_thr_new;
    end
  end

endmodule
